// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit teaching processor: datapath widths,
// register-file geometry, opcode encodings and common word/address types.
package proc_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 3;
    localparam int NUM_REGS       = 8;

    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage : proc_pkg

// File: rtl/regfile_8x16.sv
// Register file: 2**ADDR_WIDTH entries of DATA_WIDTH bits, two combinational
// read ports and one synchronous write port. Port A's address doubles as the
// write destination, matching the reg_a field used as source and destination.
// Reads never bypass an in-flight write: new data is visible after the edge.
module regfile_8x16
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage; r0 is an ordinary register, not a hardwired zero.
    logic [DATA_WIDTH-1:0] entries_q [DEPTH];
    logic [DATA_WIDTH-1:0] entries_d [DEPTH];

    // Write decode: only the entry addressed by port A takes write_data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (write_enable && (address_a == ADDR_WIDTH'(i))) begin
                entries_d[i] = write_data;
            end
        end
    end

    // State update; reset clears all entries at once and overrides any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Read multiplexers, zero-cycle latency from an address change.
    assign data_a = entries_q[address_a];
    assign data_b = entries_q[address_b];

endmodule : regfile_8x16

// File: tb/tb_regfile_8x16.sv
// Directed bench for regfile_8x16: reset, write/read, write-disable,
// read-during-write, dual-port sweep and an add/write-back flow.
module tb_regfile_8x16;

    logic        clk;
    logic        rst_n;
    logic [2:0]  address_a;
    logic [2:0]  address_b;
    logic        write_enable;
    logic [15:0] write_data;
    logic [15:0] data_a;
    logic [15:0] data_b;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_8x16 #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address_a    (address_a),
        .address_b    (address_b),
        .write_enable (write_enable),
        .write_data   (write_data),
        .data_a       (data_a),
        .data_b       (data_b)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-edge write: inputs change on the falling edge, capture on the rising one.
    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        address_a    = addr;
        write_data   = data;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    logic [15:0] sum;

    initial begin
        rst_n        = 1'b0;
        address_a    = 3'd0;
        address_b    = 3'd0;
        write_enable = 1'b0;
        write_data   = 16'h0000;
        #1;
        check("reset_initial_a", data_a, 16'h0000);
        check("reset_initial_b", data_b, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write r5 and read it on both ports
        wr(3'd5, 16'h00AB);
        address_a = 3'd5;
        address_b = 3'd5;
        #1;
        check("wr5_a", data_a, 16'h00AB);
        check("wr5_b", data_b, 16'h00AB);
        for (int i = 0; i < 8; i++) begin
            if (i != 5) begin
                address_b = 3'(i);
                #1;
                check($sformatf("others_zero_r%0d", i), data_b, 16'h0000);
            end
        end

        // Write-disable across three edges
        @(negedge clk);
        write_enable = 1'b0;
        address_a    = 3'd2;
        write_data   = 16'hFFFF;
        repeat (3) @(negedge clk);
        #1;
        check("wr_disable_r2", data_a, 16'h0000);

        // Read-during-write shows old data until the edge
        wr(3'd1, 16'h0011);
        address_a    = 3'd1;
        write_data   = 16'h0022;
        write_enable = 1'b1;
        #1;
        check("rdw_before", data_a, 16'h0011);
        @(posedge clk);
        #1;
        check("rdw_after", data_a, 16'h0022);
        @(negedge clk);
        write_enable = 1'b0;

        // Mid-cycle asynchronous reset after writing r3
        wr(3'd3, 16'h1234);
        address_a = 3'd3;
        #1;
        check("r3_loaded", data_a, 16'h1234);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address_a = 3'(i);
            address_b = 3'(7 - i);
            #1;
            check($sformatf("async_rst_a%0d", i), data_a, 16'h0000);
        end
        check("async_rst_b", data_b, 16'h0000);

        // Write attempted while reset is held is ignored
        @(negedge clk);
        address_a    = 3'd4;
        write_data   = 16'hBEEF;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("wr_during_rst", data_a, 16'h0000);

        // Dual-port independence sweep
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'h1000 + 16'(i));
        end
        for (int i = 0; i < 8; i++) begin
            address_a = 3'(i);
            address_b = 3'(7 - i);
            #1;
            check($sformatf("sweep_a%0d", i), data_a, 16'h1000 + 16'(i));
            check($sformatf("sweep_b%0d", i), data_b, 16'h1007 - 16'(i));
        end

        // Write to the port-B entry becomes visible on data_b after the edge
        address_b = 3'd6;
        wr(3'd6, 16'hA5A5);
        #1;
        check("portb_visible", data_b, 16'hA5A5);

        // Add flow: r1 = r1 + r2, written back through port A
        wr(3'd1, 16'h0005);
        wr(3'd2, 16'h0007);
        address_a = 3'd1;
        address_b = 3'd2;
        #1;
        sum = data_a + data_b;
        check("add_sum", sum, 16'h000C);
        wr(3'd1, sum);
        address_a = 3'd1;
        #1;
        check("add_writeback", data_a, 16'h000C);
        check("add_r2_kept", data_b, 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_8x16

// File: doc/regfile_8x16.md
Name: regfile_8x16

Overview:
- Register file for the 16-bit teaching processor: 8 entries × 16 bits, two combinational read ports, one synchronous write port.
- Sits between instruction decode and the execute/result logic.
- Port A's address also selects the write destination. The `reg_a` field [11:9] is both the first source and the destination for addi/add.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data ports.
- ADDR_WIDTH, 3, width of the register addresses; depth is 2**ADDR_WIDTH (8).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- address_a  input  ADDR_WIDTH  read port A address; also the write destination address.
- address_b  input  ADDR_WIDTH  read port B address.
- write_enable  input  1  when high at a rising clk edge, write_data is stored to entry address_a.
- write_data  input  DATA_WIDTH  data to be written.
- data_a  output  DATA_WIDTH  contents of entry address_a (combinational).
- data_b  output  DATA_WIDTH  contents of entry address_b (combinational).

Behaviour:
- Storage: 8 × 16-bit flip-flop registers, r0..r7. All entries, including r0, are ordinary writable registers; there is no hardwired zero.
- Reset:
  - rst_n low clears every entry to 16'h0000 immediately, independent of clk.
  - data_a and data_b therefore read 0 while rst_n is low and after reset.
  - Writes are ignored while rst_n is low.
  - Release is taken at the next rising clk edge with rst_n high.
- Write: at a rising clk edge with rst_n high and write_enable high, entry[address_a] <= write_data. With write_enable low, no entry changes.
- Read:
  - data_a = entry[address_a] and data_b = entry[address_b], purely combinational, zero-cycle latency from an address change.
  - Both ports may address the same entry and return identical data.
- Read-during-write (no bypass):
  - In the cycle a write is issued, data_a and data_b show the old contents.
  - The new value appears just after the rising edge that performs the write, i.e. one-cycle write-to-read latency.
- Simultaneous events:
  - Reset asserted in the same cycle as write_enable: reset wins and the entry stays 0.
  - A write to the entry addressed by address_b is visible on data_b after the edge.
- Widths: write_data is stored unmodified; there is no sign extension and no arithmetic inside the block. Narrower values such as the 8-bit addi immediate are zero-extended by the caller before reaching write_data.
- Addresses are always in range (2**ADDR_WIDTH entries), so no out-of-range handling is needed.
- No X on outputs after reset under any input sequence.

Decomposition:
- Shared package `proc_pkg`:
  - DATA_WIDTH = 16, REG_ADDR_WIDTH = 3, NUM_REGS = 8.
  - Opcode constants OP_ADDI = 4'b0001, OP_ADD = 4'b0010, OP_OUT = 4'b1111.
  - Typedefs `word_t` (16-bit) and `reg_addr_t` (3-bit).
- Single module, no sub-modules: the storage array, one write-decode block and two read multiplexers.

Test Plan:
- Reset: drive rst_n = 0 mid-simulation after earlier writes (r3 = 16'h1234) → data_a/data_b read 16'h0000 for every address immediately, before any clk edge.
- Write/read:
  - With write_enable = 1, address_a = 5, write_data = 16'h00AB for one edge, then address_a = 5, address_b = 5 → both outputs 16'h00AB.
  - Other entries remain 0.
- Write-disable: write_enable = 0, address_a = 2, write_data = 16'hFFFF across 3 edges → entry 2 still 16'h0000.
- Read-during-write: entry 1 = 16'h0011; issue a write of 16'h0022 to address 1 → data_a shows 16'h0011 before the edge and 16'h0022 after it.
- Dual-port independence:
  - Load r0..r7 with 16'h1000+i.
  - Sweep address_a = i and address_b = 7−i → data_a = 16'h1000+i and data_b = 16'h1007−i combinationally.
- Add-flow check:
  - Write r1 = 16'h0005 and r2 = 16'h0007, then set address_a = 1, address_b = 2 → data_a + data_b = 16'h000C.
  - Write that sum back with address_a = 1 → r1 = 16'h000C on the next read.
